// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-deep load buffer.
// New data is committed only at frame boundaries, and each digit slot is followed by a one-cycle blank gap.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_load_valid,
  input  logic [15:0] i_load_data,
  input  logic        i_load_blank,
  output logic        o_load_ready,
  output logic [7:0]  o_segments,
  output logic [3:0]  o_digit_enable,
  output logic        o_updated
);

  localparam logic [1:0]  ST_OFF   = 2'd0;
  localparam logic [1:0]  ST_SHOW  = 2'd1;
  localparam logic [1:0]  ST_GAP   = 2'd2;
  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_dig_idx;
  logic [15:0] r_div_cnt;
  logic [15:0] r_show_reg;
  logic        r_show_blank;
  logic [15:0] r_pend_reg;
  logic        r_pend_blank;
  logic        r_pend_valid;
  logic        r_updated;

  logic        w_load_acc;
  logic        w_transfer;
  logic [3:0]  w_nibble;
  logic        w_blank_digit;

  function automatic logic [6:0] f_encode(input logic [3:0] nib);
    case (nib)
      4'h0: f_encode = 7'h3F;
      4'h1: f_encode = 7'h06;
      4'h2: f_encode = 7'h5B;
      4'h3: f_encode = 7'h4F;
      4'h4: f_encode = 7'h66;
      4'h5: f_encode = 7'h6D;
      4'h6: f_encode = 7'h7D;
      4'h7: f_encode = 7'h07;
      4'h8: f_encode = 7'h7F;
      4'h9: f_encode = 7'h6F;
      4'hA: f_encode = 7'h77;
      4'hB: f_encode = 7'h7C;
      4'hC: f_encode = 7'h39;
      4'hD: f_encode = 7'h5E;
      4'hE: f_encode = 7'h79;
      default: f_encode = 7'h71;
    endcase
  endfunction

  assign o_load_ready = ~r_pend_valid;
  assign w_load_acc   = i_load_valid & ~r_pend_valid;
  // Pending data is committed from OFF, or on the gap that closes digit 3.
  assign w_transfer   = r_pend_valid &
                        ((r_state == ST_OFF) | ((r_state == ST_GAP) & (r_dig_idx == 2'd3)));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_OFF;
      r_dig_idx    <= 2'd0;
      r_div_cnt    <= 16'd0;
      r_show_reg   <= 16'd0;
      r_show_blank <= 1'b0;
      r_pend_valid <= 1'b0;
      r_updated    <= 1'b0;
    end else begin
      r_updated <= w_transfer;
      if (w_transfer) begin
        r_show_reg   <= r_pend_reg;
        r_show_blank <= r_pend_blank;
        r_pend_valid <= 1'b0;
      end else if (w_load_acc) begin
        r_pend_valid <= 1'b1;
      end
      case (r_state)
        ST_OFF: begin
          if (r_pend_valid) begin
            r_state   <= ST_SHOW;
            r_dig_idx <= 2'd0;
            r_div_cnt <= 16'd0;
          end
        end
        ST_SHOW: begin
          if (r_div_cnt == DIV_LAST) begin
            r_state <= ST_GAP;
          end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          r_state   <= ST_SHOW;
          r_dig_idx <= r_dig_idx + 2'd1;
          r_div_cnt <= 16'd0;
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_load_acc) begin
      r_pend_reg   <= i_load_data;
      r_pend_blank <= i_load_blank;
    end
  end

  // A digit is blank when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    w_nibble      = r_show_reg[3:0];
    w_blank_digit = 1'b0;
    case (r_dig_idx)
      2'd0: begin
        w_nibble      = r_show_reg[3:0];
        w_blank_digit = 1'b0;
      end
      2'd1: begin
        w_nibble      = r_show_reg[7:4];
        w_blank_digit = (r_show_reg[15:4] == 12'd0);
      end
      2'd2: begin
        w_nibble      = r_show_reg[11:8];
        w_blank_digit = (r_show_reg[15:8] == 8'd0);
      end
      default: begin
        w_nibble      = r_show_reg[15:12];
        w_blank_digit = (r_show_reg[15:12] == 4'd0);
      end
    endcase
  end

  always_comb begin
    o_digit_enable = 4'b0000;
    o_segments     = 8'h00;
    if (r_state == ST_SHOW) begin
      o_digit_enable = 4'b0001 << r_dig_idx;
      if (!(r_show_blank && w_blank_digit)) begin
        o_segments = {1'b0, f_encode(w_nibble)};
      end
    end
  end

  assign o_updated = r_updated;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_seven_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] seg;
    logic       upd;
    logic       rdy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_load_valid;
  logic [15:0] i_load_data;
  logic        i_load_blank;
  logic        o_load_ready;
  logic [7:0]  o_segments;
  logic [3:0]  o_digit_enable;
  logic        o_updated;

  exp_t q[$];
  exp_t mon_e;
  int   total;
  int   bad;
  int   cyc_no;

  seven_seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_load_valid   (i_load_valid),
    .i_load_data    (i_load_data),
    .i_load_blank   (i_load_blank),
    .o_load_ready   (o_load_ready),
    .o_segments     (o_segments),
    .o_digit_enable (o_digit_enable),
    .o_updated      (o_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc_no++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      total++;
      if (o_digit_enable !== mon_e.en || o_segments !== mon_e.seg ||
          o_updated !== mon_e.upd || o_load_ready !== mon_e.rdy) begin
        bad++;
        $display("FAIL out_vec cyc=%0d: got en=%b seg=%h upd=%b rdy=%b, want en=%b seg=%h upd=%b rdy=%b",
                 cyc_no, o_digit_enable, o_segments, o_updated, o_load_ready,
                 mon_e.en, mon_e.seg, mon_e.upd, mon_e.rdy);
      end
    end
  end

  task automatic cyc(input logic [3:0] en, input logic [7:0] seg, input logic upd, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    e.en  = en;
    e.seg = seg;
    e.upd = upd;
    e.rdy = rdy;
    q.push_back(e);
  endtask

  // Expected slots of one 20-cycle frame, cycles [from,to). Index i: digit i/5, slot cycle i%5 (4 = gap).
  task automatic frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] s3, input logic upd, input int from, input int to,
                       input int ld_at, input int acc_at, input logic [15:0] ld_data,
                       input logic ld_blank);
    logic [7:0] segs [4];
    logic [3:0] en;
    int d;
    int k;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    for (int i = from; i < to; i++) begin
      d = i / 5;
      k = i % 5;
      if (i == ld_at) begin
        i_load_valid = 1'b1;
        i_load_data  = ld_data;
        i_load_blank = ld_blank;
      end
      en = 4'b0001 << d;
      if (k == 4) cyc(4'b0000, 8'h00, 1'b0, (i < acc_at));
      else        cyc(en, segs[d], (upd && i == 0), (i < acc_at));
      if (i == acc_at) i_load_valid = 1'b0;
    end
  endtask

  task automatic check_now(input string name, input logic [13:0] act, input logic [13:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc_no       = 0;
    rst          = 1'b1;
    i_load_valid = 1'b0;
    i_load_data  = 16'h0000;
    i_load_blank = 1'b0;

    // Reset held, then idle.
    cyc(4'b0000, 8'h00, 1'b0, 1'b1);
    cyc(4'b0000, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(4'b0000, 8'h00, 1'b0, 1'b1);

    // Load 0x1252 from OFF, two identical frames.
    i_load_valid = 1'b1;
    i_load_data  = 16'h1252;
    i_load_blank = 1'b0;
    cyc(4'b0000, 8'h00, 1'b0, 1'b0);
    i_load_valid = 1'b0;
    frame(8'h5B, 8'h6D, 8'h5B, 8'h06, 1'b1, 0, 20, -1, 99, 16'h0, 1'b0);
    frame(8'h5B, 8'h6D, 8'h5B, 8'h06, 1'b0, 0, 20, -1, 99, 16'h0, 1'b0);

    // Load 0xABCD during digit 1; held until the wrap.
    frame(8'h5B, 8'h6D, 8'h5B, 8'h06, 1'b0, 0, 20, 5, 5, 16'hABCD, 1'b0);

    // Show ABCD; pend 0x0052 blanked, then hold 0xEEEE high while not ready.
    frame(8'h5E, 8'h39, 8'h7C, 8'h77, 1'b1, 0, 3, 2, 2, 16'h0052, 1'b1);
    i_load_valid = 1'b1;
    i_load_data  = 16'hEEEE;
    i_load_blank = 1'b0;
    frame(8'h5E, 8'h39, 8'h7C, 8'h77, 1'b0, 3, 20, -1, 0, 16'h0, 1'b0);
    frame(8'h5B, 8'h6D, 8'h00, 8'h00, 1'b1, 0, 20, -1, 1, 16'h0, 1'b0);

    // 0xEEEE on all digits; load 0x0000 blanked.
    frame(8'h79, 8'h79, 8'h79, 8'h79, 1'b1, 0, 20, 3, 3, 16'h0000, 1'b1);

    // 0x0000 blanked; pend 0x8888 then async reset during digit 2.
    frame(8'h3F, 8'h00, 8'h00, 8'h00, 1'b1, 0, 11, 2, 2, 16'h8888, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_now("async_reset_outputs",
              {o_digit_enable, o_segments, o_updated, o_load_ready},
              {4'b0000, 8'h00, 1'b0, 1'b1});
    cyc(4'b0000, 8'h00, 1'b0, 1'b1);
    cyc(4'b0000, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) cyc(4'b0000, 8'h00, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
